// File: rtl/afifo_wr_arb.sv
// -----------------------------------------------------------------------------
// afifo_wr_arb
// Round-robin, packet-locked arbiter sharing the single write port of an async
// FIFO (write-clock domain) among NREQ requesters. A requester wins in IDLE,
// then owns the write port until its last beat is accepted.
//
// Ports
//   wclk, wrst_n, wsrst   write clock, async active-low reset, sync soft reset
//   req_valid/last/data   per-requester beat stream (requester i at [i*DW +: DW])
//   req_ready             per-requester accept
//   wfull, awfull         registered full / almost-full from the write controller
//   winc, wdata           FIFO write strobe and data
//   gnt_id, busy          locked requester id, packet in progress
//
// Optional feature (macro AFIFO_WR_ARB_STAT_EN):
//   stall_cnt  saturating count of XFER cycles stalled by wfull with data valid
//   pkt_cnt    wrapping count of completed packets
// -----------------------------------------------------------------------------
module afifo_wr_arb #(
   parameter int NREQ = 4,
   parameter int DW   = 32,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                 wclk,
   input  logic                 wrst_n,
   input  logic                 wsrst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ-1:0]      req_last,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 wfull,
   input  logic                 awfull,
   output logic                 winc,
   output logic [DW-1:0]        wdata,
   output logic [IDW-1:0]       gnt_id,
   output logic                 busy
`ifdef AFIFO_WR_ARB_STAT_EN
   ,
   output logic [15:0]          stall_cnt,
   output logic [15:0]          pkt_cnt
`endif
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   state_t          r_state;
   logic [IDW-1:0]  r_rr_ptr;
   logic [IDW-1:0]  r_gnt_id;
   logic            r_busy;

   logic            w_found;
   logic [IDW-1:0]  w_winner;
   logic [IDW:0]    w_sum;
   logic            w_gnt_valid;
   logic            w_gnt_last;
   logic [DW-1:0]   w_wdata;
   logic            w_xfer_ok;
   logic            w_winc;
   logic            w_done;
   logic [IDW-1:0]  w_rr_next;

   // Round-robin search starting at r_rr_ptr; one extra bit on the sum handles the modulo wrap.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_sum    = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
         if (w_sum >= (IDW+1)'(NREQ)) begin
            w_sum = w_sum - (IDW+1)'(NREQ);
         end else begin
            w_sum = w_sum;
         end
         if (!w_found && req_valid[w_sum[IDW-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_sum[IDW-1:0];
         end else begin
            w_found  = w_found;
         end
      end
   end

   // Select the locked requester's valid, last and data.
   always_comb begin
      w_gnt_valid = 1'b0;
      w_gnt_last  = 1'b0;
      w_wdata     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_gnt_id == IDW'(i)) begin
            w_gnt_valid = req_valid[i];
            w_gnt_last  = req_last[i];
            w_wdata     = req_data[i*DW +: DW];
         end else begin
            w_gnt_valid = w_gnt_valid;
         end
      end
   end

   // A soft reset in flight also blocks the strobe so an aborted packet writes nothing more.
   assign w_xfer_ok = (r_state == ST_XFER) & ~wfull & ~wsrst;
   assign w_winc    = w_xfer_ok & w_gnt_valid;
   assign w_done    = w_winc & w_gnt_last;
   assign w_rr_next = (r_gnt_id == IDW'(NREQ-1)) ? '0 : (r_gnt_id + IDW'(1));

   // Ready goes only to the locked requester, and only while the FIFO can take a beat.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_gnt_id == IDW'(i)) begin
            req_ready[i] = w_xfer_ok;
         end else begin
            req_ready[i] = 1'b0;
         end
      end
   end

   assign winc   = w_winc;
   assign wdata  = w_wdata;
   assign gnt_id = r_gnt_id;
   assign busy   = r_busy;

   // Arbitration FSM: grant in IDLE, hold lock through bubbles and stalls until last beat.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_state  <= ST_IDLE;
         r_rr_ptr <= '0;
         r_gnt_id <= '0;
         r_busy   <= 1'b0;
      end else if (wsrst) begin
         r_state  <= ST_IDLE;
         r_rr_ptr <= '0;
         r_gnt_id <= '0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!awfull && w_found) begin
                  r_gnt_id <= w_winner;
                  r_state  <= ST_XFER;
                  r_busy   <= 1'b1;
               end
            end
            ST_XFER: begin
               if (w_done) begin
                  r_rr_ptr <= w_rr_next;
                  r_state  <= ST_IDLE;
                  r_busy   <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef AFIFO_WR_ARB_STAT_EN
   logic        w_stall;
   logic [15:0] r_stall_cnt;
   logic [15:0] r_pkt_cnt;

   assign w_stall = (r_state == ST_XFER) & w_gnt_valid & wfull;

   // Statistics: saturating stall counter, wrapping packet counter.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_stall_cnt <= 16'h0000;
         r_pkt_cnt   <= 16'h0000;
      end else if (wsrst) begin
         r_stall_cnt <= 16'h0000;
         r_pkt_cnt   <= 16'h0000;
      end else begin
         if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
         end
         if (w_done) begin
            r_pkt_cnt <= r_pkt_cnt + 16'h0001;
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign pkt_cnt   = r_pkt_cnt;
`endif

endmodule
